packet_deserializer: RTL and testbench

- Receive-side counterpart of the switch output port: reconstructs full DATA_WIDTH packets from the half-width beat stream the output stage drives (data + valid, no backpressure).
- Beat order is fixed: upper half first, lower half second.
- Reassembled packets are buffered in a small FIFO and presented downstream with a valid/ready handshake.
- Sits at each switch ingress or in a loopback/monitor path.

---
 rtl/packet_deserializer.sv | 162 ++++++++++++++++
 tb/tb_packet_deserializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_deserializer.sv
// rtl/packet_deserializer.sv - Rebuilds full-width packets from an upper/lower half-beat stream
//
// packet_pkg      : shared packet width (DATA_WIDTH).
// packet_deserializer
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   data_in     in   half-width beat (upper half first, then lower half)
//   valid_in    in   beat qualifier, no backpressure on this side
//   pkt_out     out  FIFO head packet {upper, lower}, 0 while empty
//   pkt_valid   out  FIFO non-empty
//   pkt_ready   in   downstream accept, pops on pkt_valid & pkt_ready
//   overflow    out  one-cycle pulse, completed packet dropped (FIFO full)
//   frame_err   out  one-cycle pulse, partial packet dropped (gap timeout)
//   drop_count  out  saturating drop counter, present only with DESER_STATS_EN
//
// Build option: define DESER_STATS_EN to instantiate the drop counter;
// otherwise drop_count is tied to 0.

package packet_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

module packet_deserializer #(
    parameter int DATA_WIDTH  = packet_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH/2-1:0] data_in,
    input  logic                    valid_in,
    output logic [DATA_WIDTH-1:0]   pkt_out,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic                    overflow,
    output logic                    frame_err,
    output logic [7:0]              drop_count
);

    localparam int HW = DATA_WIDTH / 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_C   = GW'(GAP_TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [HW-1:0]   upper, upper_next;
    logic [GW-1:0]   gap, gap_next, gap_inc;
    logic            push, pop;
    logic            overflow_next, frame_err_next;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    assign pkt_valid = (count != '0);
    assign pop       = pkt_valid & pkt_ready;
    assign pkt_out   = pkt_valid ? mem[rd_ptr] : '0;
    assign gap_inc   = gap + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            upper <= '0;
            gap   <= '0;
        end else begin
            state <= state_next;
            upper <= upper_next;
            gap   <= gap_next;
        end
    end

    always_comb begin
        state_next     = state;
        upper_next     = upper;
        gap_next       = gap;
        push           = 1'b0;
        overflow_next  = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    upper_next = data_in;
                    gap_next   = '0;
                    state_next = HALF;
                end
            end
            HALF: begin
                if (valid_in) begin
                    state_next = IDLE;
                    // A pop on the same edge frees a slot even when full.
                    if (count != DEPTH_C || pop) begin
                        push = 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end else if (gap_inc == GAP_C) begin
                    frame_err_next = 1'b1;
                    gap_next       = '0;
                    state_next     = IDLE;
                end else begin
                    gap_next = gap_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage needs no reset: pkt_out is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {upper, data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= overflow_next;
            frame_err <= frame_err_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DESER_STATS_EN
    logic [7:0] drops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drops <= '0;
        end else if ((overflow || frame_err) && drops != 8'hFF) begin
            drops <= drops + 8'd1;
        end
    end

    assign drop_count = drops;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_packet_deserializer.sv
// tb/tb_packet_deserializer.sv - Self-checking bench for packet_deserializer

module tb_packet_deserializer;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        valid_in;
    logic [31:0] pkt_out;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        overflow;
    logic        frame_err;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    // Reference state: packet queue plus the pending upper half.
    logic [31:0] exp_q[$];
    bit          have_upper;
    logic [15:0] upper_m;
    int          idle_m;
    bit          ov_m, fe_m;
    int          drops_m;

    packet_deserializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_drops();
`ifdef DESER_STATS_EN
        return 32'(drops_m);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        have_upper = 0;
        upper_m    = '0;
        idle_m     = 0;
        ov_m       = 0;
        fe_m       = 0;
        drops_m    = 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit v, input logic [15:0] d, input bit rdy);
        bit          do_pop;
        bit          do_push;
        logic [31:0] pkt;
        valid_in  = v;
        data_in   = d;
        pkt_ready = rdy;
        @(posedge clk);
        #1;
        if ((ov_m || fe_m) && drops_m < 255) drops_m++;
        do_pop  = (exp_q.size() > 0) && rdy;
        do_push = 0;
        pkt     = '0;
        ov_m    = 0;
        fe_m    = 0;
        if (!have_upper) begin
            if (v) begin
                have_upper = 1;
                upper_m    = d;
                idle_m     = 0;
            end
        end else if (v) begin
            have_upper = 0;
            pkt        = {upper_m, d};
            if (exp_q.size() < 4 || do_pop) do_push = 1;
            else ov_m = 1;
        end else begin
            idle_m++;
            if (idle_m == 8) begin
                have_upper = 0;
                fe_m       = 1;
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(pkt);

        chk("pkt_valid", 32'(pkt_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("pkt_out", pkt_out, exp_q[0]);
        chk("overflow", 32'(overflow), 32'(ov_m));
        chk("frame_err", 32'(frame_err), 32'(fe_m));
        chk("drop_count", 32'(drop_count), exp_drops());
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        pkt_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst_pkt_out", pkt_out, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reassembly and latency
        step(1, 16'hDEAD, 1);
        chk("half_no_valid", 32'(pkt_valid), 32'd0);
        step(1, 16'hBEEF, 1);
        chk("reassemble", pkt_out, 32'hDEADBEEF);
        step(0, 16'h0, 1);
        chk("one_cycle_valid", 32'(pkt_valid), 32'd0);

        // FIFO fill and overflow
        for (int i = 0; i < 4; i++) begin
            step(1, 16'hA000 + 16'(i), 0);
            step(1, 16'hB000 + 16'(i), 0);
            chk("fill_no_ovf", 32'(overflow), 32'd0);
        end
        chk("full_valid", 32'(pkt_valid), 32'd1);
        step(1, 16'hC0C0, 0);
        step(1, 16'hD0D0, 0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_head_kept", pkt_out, 32'hA000B000);
        step(0, 16'h0, 0);
        chk("ovf_single", 32'(overflow), 32'd0);
        step(1, 16'hC1C1, 0);
        step(1, 16'hD1D1, 1);
        chk("push_pop_full_no_ovf", 32'(overflow), 32'd0);
        repeat (6) step(0, 16'h0, 1);
        chk("drained", 32'(pkt_valid), 32'd0);

        // Gap tolerance and timeout
        step(1, 16'h1234, 1);
        repeat (7) step(0, 16'h0, 1);
        step(1, 16'h5678, 1);
        chk("gap7_pkt", pkt_out, 32'h12345678);
        chk("gap7_no_ferr", 32'(frame_err), 32'd0);
        step(0, 16'h0, 1);
        step(1, 16'h9999, 1);
        repeat (8) step(0, 16'h0, 1);
        chk("gap8_ferr", 32'(frame_err), 32'd1);
        step(1, 16'hAAAA, 1);
        chk("ferr_single", 32'(frame_err), 32'd0);
        step(1, 16'hBBBB, 1);
        chk("after_ferr_upper", pkt_out, 32'hAAAABBBB);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(5, 10)) step(0, 16'($urandom), $urandom_range(0, 1) == 1);
            end
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 2) != 0);
        end
        repeat (6) step(0, 16'h0, 1);

        // Saturation via repeated timeouts
        for (int i = 0; i < 300; i++) begin
            step(1, 16'($urandom), 1);
            repeat (8) step(0, 16'h0, 1);
        end
        repeat (2) step(0, 16'h0, 1);
`ifdef DESER_STATS_EN
        chk("saturated", 32'(drop_count), 32'd255);
`else
        chk("no_stats", 32'(drop_count), 32'd0);
`endif

        // Async reset mid-packet with queued packets
        step(1, 16'h1111, 0);
        step(1, 16'h2222, 0);
        step(1, 16'h3333, 0);
        step(1, 16'h4444, 0);
        step(1, 16'h5555, 0);
        chk("pre_rst_valid", 32'(pkt_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_frame_err", 32'(frame_err), 32'd0);
        chk("arst_pkt_out", pkt_out, 32'd0);
        chk("arst_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 16'h0001, 1);
        step(1, 16'h0002, 1);
        chk("post_rst_pkt", pkt_out, 32'h00010002);
        repeat (9) step(0, 16'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
